// File: rtl/rr_grant_ctrl_pkg.sv
// Shared types and default sizing for the round-robin grant controller.
package rr_grant_ctrl_pkg;

  // Arbiter FSM encoding.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam int N_DEF        = 4;
  localparam int IDXW_DEF     = 2;
  localparam int MAX_HOLD_DEF = 8;

endpackage

// File: rtl/rr_grant_ctrl_if.sv
// Request/grant bundle between requesters and the round-robin controller.
//
// Handshake: req[i] is a level request held by requester i for as long as it
// wants the resource. grant is a registered one-hot level; grant_valid
// qualifies grant and grant_idx, and there is no backpressure on the grant
// side. preempt is a single-cycle pulse that marks a grant revoked by timeout.
// state exposes the arbiter FSM for observation.
interface rr_grant_ctrl_if #(
  parameter int N    = rr_grant_ctrl_pkg::N_DEF,
  parameter int IDXW = rr_grant_ctrl_pkg::IDXW_DEF
) ();
  import rr_grant_ctrl_pkg::*;

  logic            en;
  logic [N-1:0]    req;
  logic [N-1:0]    grant;
  logic [IDXW-1:0] grant_idx;
  logic            grant_valid;
  logic            preempt;
  state_e          state;

  // Requester side: drives requests and enable, observes grants.
  modport master (
    output en, req,
    input  grant, grant_idx, grant_valid, preempt, state
  );

  // Arbiter side.
  modport slave (
    input  en, req,
    output grant, grant_idx, grant_valid, preempt, state
  );
endinterface

// File: rtl/rr_grant_ctrl_onehot_dec.sv
// Binary-to-one-hot decoder; output is all zeros while EN is low.
module onehot_dec #(
  parameter int N    = 4,
  parameter int IDXW = 2
) (
  input  logic [IDXW-1:0] x,
  input  logic            EN,
  output logic [N-1:0]    y
);

  // Set the single bit selected by x when enabled.
  always_comb begin
    y = '0;
    if (EN) y[x] = 1'b1;
  end

endmodule

// File: rtl/rr_grant_ctrl.sv
// Round-robin arbiter: one registered one-hot grant among N requesters, with
// release-driven rotation and a hold timeout that preempts a long owner only
// when someone else is waiting.
module rr_grant_ctrl
  import rr_grant_ctrl_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int IDXW     = IDXW_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input logic             clk,
  input logic             rst_n,
  rr_grant_ctrl_if.slave  bus
);

  localparam int HOLDW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLDW-1:0] HOLD_MAX = HOLDW'(MAX_HOLD - 1);

  state_e            state_q, state_d;
  logic [IDXW-1:0]   ptr_q, ptr_d;
  logic [IDXW-1:0]   idx_q, next_idx;
  logic [HOLDW-1:0]  hold_q, hold_d;
  logic [N-1:0]      grant_q, next_grant;
  logic              preempt_q, preempt_d;
  logic              next_valid;

  logic [IDXW-1:0]   o_next;
  logic [N-1:0]      others;
  logic [IDXW:0]     idle_scan;
  logic [IDXW:0]     rot_scan;

  // Cyclic first-set scan starting at 'start'; returns {found, index}.
  function automatic logic [IDXW:0] scan(input logic [N-1:0] mask,
                                         input logic [IDXW-1:0] start);
    logic            found;
    logic [IDXW-1:0] win;
    logic [IDXW-1:0] cand;
    found = 1'b0;
    win   = start;
    for (int i = 0; i < N; i++) begin
      cand = start + IDXW'(i);
      if (!found && mask[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    return {found, win};
  endfunction

  // In GRANT, grant_q is one-hot at the owner, so this masks the owner out.
  assign others    = bus.req & ~grant_q;
  assign o_next    = idx_q + IDXW'(1);
  assign idle_scan = scan(bus.req, ptr_q);
  assign rot_scan  = scan(others, o_next);

  // Next-state, next owner and hold-counter decisions.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_d     = hold_q;
    next_idx   = idx_q;
    next_valid = 1'b0;
    preempt_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.en && (|bus.req)) begin
          next_valid = 1'b1;
          next_idx   = idle_scan[IDXW-1:0];
          hold_d     = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (!bus.en) begin
          // Abort: drop the grant but keep the rotation point.
          state_d = IDLE;
          hold_d  = '0;
        end else if (!bus.req[idx_q]) begin
          // Release has priority over timeout; hand over with no dead cycle.
          ptr_d  = o_next;
          hold_d = '0;
          if (rot_scan[IDXW]) begin
            next_valid = 1'b1;
            next_idx   = rot_scan[IDXW-1:0];
          end else begin
            state_d = IDLE;
          end
        end else if ((hold_q == HOLD_MAX) && (|others)) begin
          ptr_d      = o_next;
          next_valid = 1'b1;
          next_idx   = rot_scan[IDXW-1:0];
          hold_d     = '0;
          preempt_d  = 1'b1;
        end else begin
          next_valid = 1'b1;
          if (hold_q != HOLD_MAX) hold_d = hold_q + HOLDW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  onehot_dec #(.N(N), .IDXW(IDXW)) u_dec (
    .x  (next_idx),
    .EN (next_valid),
    .y  (next_grant)
  );

  // State, pointer, counter and grant output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      hold_q    <= '0;
      grant_q   <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= next_idx;
      hold_q    <= hold_d;
      grant_q   <= next_grant;
      preempt_q <= preempt_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = |grant_q;
  assign bus.grant_idx   = idx_q;
  assign bus.preempt     = preempt_q;
  assign bus.state       = state_q;

endmodule
